// File: rtl/cordic_quadrant_pipe.sv
// rtl/cordic_quadrant_pipe.sv - CORDIC quadrant pre-fold with elastic valid/ready pipeline
//
// Folds an input vector (vectoring) or a target angle (rotation) into the
// -90..+90 degree convergence range ahead of the CORDIC iteration chain.
// Stage 1 computes the fold; stages 2..STAGES are plain register slices.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   mode                     0 = vectoring, 1 = rotation
//   x_in, y_in               signed vector components (WIDTH)
//   angle_in                 accumulator seed (vectoring) / target angle (rotation)
//   out_valid/out_ready      output handshake
//   x_out, y_out, angle_out  folded vector and corrected angle
//   mode_out                 mode carried with the data
//   quad_out                 00 none, 01 rotated -90, 10 rotated +90
//   sat_out                  a negation in this transaction saturated
module cordic_quadrant_pipe #(
    parameter int WIDTH       = 32,
    parameter int ANGLE_WIDTH = 32,
    parameter int STAGES      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       x_in,
    input  logic [WIDTH-1:0]       y_in,
    input  logic [ANGLE_WIDTH-1:0] angle_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       x_out,
    output logic [WIDTH-1:0]       y_out,
    output logic [ANGLE_WIDTH-1:0] angle_out,
    output logic                   mode_out,
    output logic [1:0]             quad_out,
    output logic                   sat_out
);

    localparam logic [WIDTH-1:0]       MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]       MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [ANGLE_WIDTH-1:0] QUARTER = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0]       x;
        logic [WIDTH-1:0]       y;
        logic [ANGLE_WIDTH-1:0] a;
        logic                   m;
        logic [1:0]             q;
        logic                   s;
    } slot_t;

    slot_t             slot_q [STAGES];
    slot_t             slot_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] up_v;

    slot_t             fold;
    logic [WIDTH-1:0]  neg_x;
    logic [WIDTH-1:0]  neg_y;
    logic              sat_nx;
    logic              sat_ny;

    // Quadrant fold of the incoming transaction
    always_comb begin
        sat_nx = (x_in == MIN_VAL);
        sat_ny = (y_in == MIN_VAL);
        neg_x  = sat_nx ? MAX_VAL : -x_in;
        neg_y  = sat_ny ? MAX_VAL : -y_in;

        fold.x = x_in;
        fold.y = y_in;
        fold.a = angle_in;
        fold.m = mode;
        fold.q = 2'b00;
        fold.s = 1'b0;

        if (!mode) begin
            // Vectoring: only a left-half-plane vector needs folding
            if (x_in[WIDTH-1]) begin
                if (!y_in[WIDTH-1]) begin
                    fold.x = y_in;
                    fold.y = neg_x;
                    fold.a = angle_in + QUARTER;
                    fold.q = 2'b01;
                    fold.s = sat_nx;
                end else begin
                    fold.x = neg_y;
                    fold.y = x_in;
                    fold.a = angle_in - QUARTER;
                    fold.q = 2'b10;
                    fold.s = sat_ny;
                end
            end
        end else begin
            // Rotation: top two angle bits give the quadrant of the target
            case (angle_in[ANGLE_WIDTH-1 -: 2])
                2'b01: begin
                    fold.x = neg_y;
                    fold.y = x_in;
                    fold.a = angle_in - QUARTER;
                    fold.q = 2'b10;
                    fold.s = sat_ny;
                end
                2'b10: begin
                    fold.x = y_in;
                    fold.y = neg_x;
                    fold.a = angle_in + QUARTER;
                    fold.q = 2'b01;
                    fold.s = sat_nx;
                end
                default: begin
                    fold.q = 2'b00;
                end
            endcase
        end
    end

    // Ready chain runs from the output back to the input, so a full pipe
    // still accepts when the output pops in the same cycle.
    always_comb begin : ready_chain
        logic down_ready;
        down_ready = out_ready;
        up_v[0]    = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            up_v[s] = v_q[s-1];
        end
        adv  = '0;
        load = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s]     = v_q[s] && down_ready;
            down_ready = !v_q[s] || adv[s];
            load[s]    = up_v[s] && down_ready;
        end
        in_ready = down_ready;
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            v_d[s]    = load[s] || (v_q[s] && !adv[s]);
            slot_d[s] = slot_q[s];
        end
        if (load[0]) begin
            slot_d[0] = fold;
        end
        for (int s = 1; s < STAGES; s++) begin
            if (load[s]) begin
                slot_d[s] = slot_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int s = 0; s < STAGES; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign x_out     = slot_q[STAGES-1].x;
    assign y_out     = slot_q[STAGES-1].y;
    assign angle_out = slot_q[STAGES-1].a;
    assign mode_out  = slot_q[STAGES-1].m;
    assign quad_out  = slot_q[STAGES-1].q;
    assign sat_out   = slot_q[STAGES-1].s;

endmodule

// File: tb/tb_cordic_quadrant_pipe.sv
// tb/tb_cordic_quadrant_pipe.sv - randomized and directed bench for cordic_quadrant_pipe
module tb_cordic_quadrant_pipe;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic [31:0] angle_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [31:0] angle_out;
    logic        mode_out;
    logic [1:0]  quad_out;
    logic        sat_out;

    cordic_quadrant_pipe #(.WIDTH(32), .ANGLE_WIDTH(32), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .angle_out(angle_out),
        .mode_out(mode_out), .quad_out(quad_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] a;
        logic        m;
        logic [1:0]  q;
        logic        s;
        int          cyc;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           lat_mode = 0;
    bit           held_valid = 0;
    logic [127:0] held = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Saturating negation on true integers
    function automatic longint neg_sat(input longint v, inout bit sat);
        longint r = -v;
        if (r > 64'sd2147483647) begin
            r   = 64'sd2147483647;
            sat = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t model(input bit m, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] a);
        exp_t   e;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint za = longint'($signed(a));
        longint quarter = 64'sd1 << 30;
        longint nx = sx;
        longint ny = sy;
        longint na = za;
        bit     sat = 0;
        e.q = 2'b00;
        if (!m) begin
            if (sx < 0 && sy >= 0) begin
                nx = sy; ny = neg_sat(sx, sat); na = za + quarter; e.q = 2'b01;
            end else if (sx < 0) begin
                nx = neg_sat(sy, sat); ny = sx; na = za - quarter; e.q = 2'b10;
            end
        end else begin
            if (za >= quarter) begin
                nx = neg_sat(sy, sat); ny = sx; na = za - quarter; e.q = 2'b10;
            end else if (za < -quarter) begin
                nx = sy; ny = neg_sat(sx, sat); na = za + quarter; e.q = 2'b01;
            end
        end
        e.x   = 32'(nx);
        e.y   = 32'(ny);
        e.a   = 32'(na);
        e.m   = m;
        e.s   = sat;
        e.cyc = 0;
        return e;
    endfunction

    // One clock: drive at the falling edge, observe 1 ns later, model the handshakes.
    task automatic step(input bit iv, input bit m, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] a, input bit ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; mode = m; x_in = x; y_in = y; angle_in = a; out_ready = ordy;
        #1;
        check("in_ready", 128'(in_ready), 128'(!(q.size() == STAGES && !ordy)));
        if (q.size() == 0) check("idle_out_valid", 128'(out_valid), 128'(0));
        if (held_valid && out_valid) check("stall_hold", {x_out, y_out, angle_out}, held);
        held_valid = out_valid && !ordy;
        held       = {x_out, y_out, angle_out};
        if (out_valid && ordy && q.size() > 0) begin
            e = q.pop_front();
            check("x_out", 128'(x_out), 128'(e.x));
            check("y_out", 128'(y_out), 128'(e.y));
            check("angle_out", 128'(angle_out), 128'(e.a));
            check("mode_out", 128'(mode_out), 128'(e.m));
            check("quad_out", 128'(quad_out), 128'(e.q));
            check("sat_out", 128'(sat_out), 128'(e.s));
            if (lat_mode) check("latency", 128'(cyc - e.cyc), 128'(STAGES));
        end
        acc = iv && in_ready;
        if (acc) begin
            e     = model(m, x, y, a);
            e.cyc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            step(0, 0, 0, 0, 0, 1, acc);
            n++;
        end
        check("drain_empty", 128'(q.size()), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_data", {x_out, y_out, angle_out}, 128'(0));
        check("rst_flags", 128'({mode_out, quad_out, sat_out}), 128'(0));
        rst = 1'b0;
        q.delete();
        held_valid = 0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] specials [5] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h1};
        if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        bit          acc;
        int          idx;
        int          c;
        logic [31:0] tx [10];

        do_reset();

        // Directed cases, out_ready held high, latency checked
        lat_mode = 1;
        step(1, 0, -32'sd1000, 32'sd500, 32'h00000000, 1, acc);
        step(1, 0, -32'sd1000, -32'sd500, 32'h10000000, 1, acc);
        step(1, 1, 32'sd1000, 32'sd0, 32'h60000000, 1, acc);
        step(1, 1, 32'sd7, 32'sd9, 32'h80000000, 1, acc);
        step(1, 0, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1, acc);
        step(1, 1, 32'h80000000, 32'h5, 32'hA0000000, 1, acc);
        drain();
        lat_mode = 0;

        // Ten back-to-back inputs with a stall in cycles 3..8
        for (int i = 0; i < 10; i++) tx[i] = $urandom;
        idx = 0;
        c   = 1;
        while (idx < 10 && c < 100) begin
            step(1, tx[idx][0], tx[idx], ~tx[idx], tx[idx] ^ 32'h5A5A5A5A,
                 !(c >= 3 && c <= 8), acc);
            if (acc) idx++;
            c++;
        end
        check("burst_accepted", 128'(idx), 128'(10));
        drain();

        // Reset with two transactions in flight
        step(1, 0, -32'sd5, 32'sd3, 32'h1, 0, acc);
        step(1, 1, 32'sd5, 32'sd3, 32'h50000000, 0, acc);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, acc);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, $urandom_range(1), pick(), pick(), pick(),
                 $urandom_range(3) != 0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_quadrant_pipe.md
Name: cordic_quadrant_pipe

Overview:
- Parametrised, pipelined CORDIC pre-rotation stage that folds any input vector or target angle into the −90°..+90° convergence range before the CORDIC iteration chain.
- Supports vectoring and rotation modes, selected per transaction.
- Carries the angle accumulator through the fold.
- Valid/ready elastic pipeline of configurable depth, feeding the CORDIC core in both the vectoring and rotating top levels.

Parameters:
- WIDTH, 32, two's-complement width of x/y.
- ANGLE_WIDTH, 32, width of angle; full scale 2^ANGLE_WIDTH = 360°, so 90° = 2^(ANGLE_WIDTH-2).
- STAGES, 2, pipeline depth, ≥1. Stage 1 computes; stages 2..STAGES are register slices.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- mode  in  1  0 = vectoring, 1 = rotation; sampled with the transaction
- x_in  in  WIDTH  signed x
- y_in  in  WIDTH  signed y
- angle_in  in  ANGLE_WIDTH  vectoring: accumulator seed; rotation: target angle
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts
- x_out  out  WIDTH  folded x
- y_out  out  WIDTH  folded y
- angle_out  out  ANGLE_WIDTH  corrected accumulator / residual angle
- mode_out  out  1  mode travelling with the data
- quad_out  out  2  fold code: 00 none, 01 rotated −90°, 10 rotated +90°
- sat_out  out  1  negation saturated in this transaction

Behaviour:
- Reset (synchronous):
  - All stage valid bits 0; all data registers 0.
  - Outputs after reset: out_valid=0, x_out=y_out=angle_out=0, quad_out=00, mode_out=0, sat_out=0, in_ready=1.
  - Reset mid-operation discards all in-flight transactions with no output.
- Vectoring (mode=0), decided on x_in[W-1], y_in[W-1]:
  - x≥0: pass x, y; angle_out = angle_in; quad 00.
  - x<0, y≥0: x'=y, y'=−x; angle_out = angle_in + 90°; quad 01.
  - x<0, y<0: x'=−y, y'=x; angle_out = angle_in − 90°; quad 10.
- Rotation (mode=1), decided on angle_in[AW-1:AW-2]:
  - 01 (z ≥ +90°): x'=−y, y'=x; angle_out = z − 90°; quad 10.
  - 10 (z < −90°): x'=y, y'=−x; angle_out = z + 90°; quad 01.
  - 00 / 11: pass; angle_out = z; quad 00.
- Arithmetic:
  - Angle add/sub is modulo 2^ANGLE_WIDTH (wrap, no saturation).
  - Negation of −2^(W-1) saturates to 2^(W-1)−1 and sets sat_out for that transaction; all other negations are exact.
- Pipeline:
  - A stage loads when its upstream is valid and it is either empty or its contents advance this cycle.
  - in_ready = !v[1] || advance[1]; combinational ready chain from out_ready is permitted.
  - Latency exactly STAGES cycles with out_ready held high; throughput 1 transaction/cycle.
  - Ordering preserved; no drop or duplication.
  - Under stall (out_ready=0) outputs hold stable, and the pipe absorbs up to STAGES transactions, then in_ready=0.
  - Simultaneous pop at the output and push at the input when full: accepted, no bubble.
- Idle: when a stage is empty its data registers hold their last value; only the valid bit is meaningful.

Test Plan:
1. Vectoring, x=−1000, y=500, angle=0 -> after 2 cycles: x_out=500, y_out=1000, angle_out=0x40000000, quad 01.
2. Vectoring, x=−1000, y=−500, angle=0x10000000 -> x_out=500, y_out=−1000, angle_out=0xD0000000, quad 10.
3. Rotation, x=1000, y=0, angle=0x60000000 (135°) -> x_out=0, y_out=1000, angle_out=0x20000000, quad 10.
4. Rotation, angle=0x80000000 (−180°) -> angle_out=0xC0000000, quad 01. Vectoring, x=−1, y=0x80000000 -> x_out=0x7FFFFFFF, sat_out=1.
5. Stream 10 back-to-back inputs with out_ready=0 for cycles 3–8:
   - in_ready drops after 2 accepted inputs.
   - All 10 transactions emerge in order, values unchanged, none lost.
6. Assert rst with 2 transactions in flight -> next cycle out_valid=0, in_ready=1, outputs 0; no stale transaction emerges afterwards.
